// File: rtl/smem_out_pkg.sv
// Shared types and constants for the SMEM output writer: line type, writer FSM
// states, default host line stride and a saturating counter helper.
package smem_out_pkg;

  localparam int LINE_W         = 512;
  localparam int DEF_LINE_BYTES = 64;

  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    STREAM,
    DRAIN,
    DONE
  } wr_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/smem_out_fifo.sv
// Result-line FIFO with first-word-fall-through head. The head is read straight
// from the array at the registered read pointer, so a line pushed on one edge is
// visible (and non-empty asserted) right after that edge. A push into a full FIFO
// is dropped unless a pop frees a slot on the same edge; drop flags that case.
module smem_out_fifo
  import smem_out_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  line_t                    din,
  output line_t                    head,
  output logic                     empty,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  line_t          mem [DEPTH];
  logic [PW-1:0]  wr_ptr_reg;
  logic [PW-1:0]  rd_ptr_reg;
  logic [CW-1:0]  count_reg;
  logic           full;
  logic           pop_ok;
  logic           push_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage array: written at the tail, no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/smem_output_writer.sv
// SMEM output writer: grants the upstream batch, buffers result lines in a FIFO
// and streams them to host memory as consecutive LINE_BYTES-sized writes.
// Optional build macro OUT_WRITER_PERF_CNT_EN adds stall_cycles and
// host_wait_cycles saturating performance counters.
module smem_output_writer
  import smem_out_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 64,
  parameter int LINE_BYTES = DEF_LINE_BYTES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              output_request,
  output logic              output_permit,
  input  logic [LINE_W-1:0] output_data,
  input  logic              output_valid,
  input  logic              output_finish,
  output logic              stall,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LINE_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic              done,
  output logic [31:0]       lines_written,
  output logic              overflow_err
`ifdef OUT_WRITER_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       host_wait_cycles
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wr_state_t         state_reg, state_next;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_drop;
  line_t             fifo_head;
  logic              in_stream, start_ok, push, pop;
  logic              permit_reg, done_reg, ovf_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       lines_reg;

  assign in_stream = (state_reg == STREAM) || (state_reg == DRAIN);
  assign start_ok  = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign push      = output_valid && in_stream;
  assign wr_valid  = !fifo_empty;
  assign pop       = wr_valid && wr_ready;
  // Two spare slots absorb the line upstream may still send after stall rises.
  assign stall     = (fifo_count >= CW'(FIFO_DEPTH - 2));

  assign output_permit = permit_reg;
  assign done          = done_reg;
  assign overflow_err  = ovf_reg;
  assign wr_addr       = addr_reg;
  assign wr_data       = fifo_head;
  assign lines_written = lines_reg;

  smem_out_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (output_data),
    .head  (fifo_head),
    .empty (fifo_empty),
    .drop  (fifo_drop),
    .count (fifo_count)
  );

  // Writer FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; DRAIN also waits out a late push so no line is stranded.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start) state_next = ARMED;
      ARMED:   if (output_request) state_next = STREAM;
      STREAM:  if (output_finish) state_next = DRAIN;
      DRAIN:   if (fifo_empty && !push) state_next = DONE;
      DONE:    if (start) state_next = ARMED;
      default: state_next = IDLE;
    endcase
  end

  // Permit and done are registered decodes of the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      permit_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      permit_reg <= (state_next == STREAM) || (state_next == DRAIN);
      done_reg   <= (state_next == DONE);
    end
  end

  // Host address, line count and sticky overflow; all re-armed by start.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg  <= '0;
      lines_reg <= '0;
      ovf_reg   <= 1'b0;
    end else if (start_ok) begin
      addr_reg  <= base_addr;
      lines_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      if (pop) begin
        addr_reg  <= addr_reg + ADDR_W'(LINE_BYTES);
        lines_reg <= lines_reg + 32'd1;
      end
      if (fifo_drop) ovf_reg <= 1'b1;
    end
  end

`ifdef OUT_WRITER_PERF_CNT_EN
  logic [31:0] stall_cyc_reg;
  logic [31:0] host_wait_reg;

  assign stall_cycles     = stall_cyc_reg;
  assign host_wait_cycles = host_wait_reg;

  // Saturating counts of pipeline stall cycles and host back-pressure cycles.
  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      stall_cyc_reg <= '0;
      host_wait_reg <= '0;
    end else begin
      if (stall && in_stream)     stall_cyc_reg <= sat_inc32(stall_cyc_reg);
      if (wr_valid && !wr_ready)  host_wait_reg <= sat_inc32(host_wait_reg);
    end
  end
`endif

endmodule

// File: tb/tb_smem_output_writer.sv
// Self-checking bench for smem_output_writer: random line payloads, expected host
// writes derived from the batch base address and the order lines were offered.
module tb_smem_output_writer;
  import smem_out_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset, start, output_request, output_valid, output_finish, wr_ready;
  logic [63:0] base_addr;
  line_t       output_data;
  logic        output_permit, stall, wr_valid, done, overflow_err;
  logic [63:0] wr_addr;
  line_t       wr_data;
  logic [31:0] lines_written;
`ifdef OUT_WRITER_PERF_CNT_EN
  logic [31:0] stall_cycles, host_wait_cycles;
`endif

  smem_output_writer #(.FIFO_DEPTH(DEPTH), .ADDR_W(64), .LINE_BYTES(64)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .output_request(output_request), .output_permit(output_permit),
    .output_data(output_data), .output_valid(output_valid),
    .output_finish(output_finish), .stall(stall), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready), .done(done),
    .lines_written(lines_written), .overflow_err(overflow_err)
`ifdef OUT_WRITER_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .host_wait_cycles(host_wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Host-side monitor: records accepted writes and wr_addr/wr_data stability.
  logic [63:0] cap_addr[$];
  line_t       cap_data[$];
  int          cap_cyc[$];
  logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_reset = 1'b1;
  logic [63:0] prev_addr;
  line_t       prev_data;
  int          unstable = 0;
  bit          watch = 1'b0;
  bit          toggle = 1'b0;

  always @(negedge clk) begin
    if (watch && prev_valid && !prev_ready && !prev_reset &&
        (!wr_valid || wr_addr !== prev_addr || wr_data !== prev_data))
      unstable <= unstable + 1;
    prev_valid <= wr_valid;
    prev_ready <= wr_ready;
    prev_reset <= reset;
    prev_addr  <= wr_addr;
    prev_data  <= wr_data;
    if (wr_valid === 1'b1 && wr_ready === 1'b1 && reset === 1'b0) begin
      cap_addr.push_back(wr_addr);
      cap_data.push_back(wr_data);
      cap_cyc.push_back(cyc);
      $display("host write addr=%h data_lo=%h", wr_addr, wr_data[63:0]);
    end
  end

  line_t sent_q[$];

  function automatic line_t rnd_line();
    line_t r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle) wr_ready = ~wr_ready;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; base_addr = '0; output_request = 1'b0;
    output_valid = 1'b0; output_finish = 1'b0; output_data = '0; wr_ready = 1'b0;
    toggle = 1'b0; watch = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic begin_batch(input logic [63:0] base, output bit ok);
    start = 1'b1; base_addr = base;
    tick();
    start = 1'b0; output_request = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (output_permit === 1'b1) ok = 1'b1;
    end
    output_request = 1'b0;
  endtask

  task automatic send_lines(input int n, input bit honour);
    int sent = 0;
    for (int g = 0; g < 2000 && sent < n; g++) begin
      if (!honour || stall !== 1'b1) begin
        output_valid = 1'b1;
        output_data  = rnd_line();
        sent_q.push_back(output_data);
        sent++;
      end else begin
        output_valid = 1'b0;
      end
      tick();
    end
    output_valid = 1'b0;
  endtask

  task automatic finish_wait(output bit ok, output int done_cyc);
    output_finish = 1'b1;
    ok = 1'b0; done_cyc = -1;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      if (done === 1'b1) begin ok = 1'b1; done_cyc = cyc; end
    end
    output_finish = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({output_permit, stall, wr_valid, done, overflow_err} !== 5'b0 ||
        lines_written !== 32'd0 || wr_addr !== 64'd0) begin
      bad++;
      $display("FAIL reset_state got permit=%b stall=%b wr_valid=%b done=%b ovf=%b lw=%0d addr=%h want all zero",
               output_permit, stall, wr_valid, done, overflow_err, lines_written, wr_addr);
    end
  endtask

  task automatic test_basic();
    bit ok; int dc; int i0; logic [63:0] ea;
    sent_q.delete(); i0 = cap_addr.size(); wr_ready = 1'b1;
    begin_batch(64'h1000, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_permit got 0 want 1"); end
    send_lines(5, 1'b1);
    finish_wait(ok, dc);
    total++; if (!ok) begin bad++; $display("FAIL basic_done got timeout want done=1"); end
    total++;
    if (cap_addr.size() - i0 !== 5) begin
      bad++; $display("FAIL basic_count got %0d writes want 5", cap_addr.size() - i0);
    end else begin
      for (int k = 0; k < 5; k++) begin
        ea = 64'h1000 + 64'(k) * 64'h40;
        total++;
        if (cap_addr[i0+k] !== ea || cap_data[i0+k] !== sent_q[k]) begin
          bad++; $display("FAIL basic_line%0d got addr=%h data_lo=%h want addr=%h data_lo=%h",
                          k, cap_addr[i0+k], cap_data[i0+k][63:0], ea, sent_q[k][63:0]);
        end
      end
      total++;
      if (dc !== cap_cyc[i0+4] + 2) begin
        bad++; $display("FAIL basic_done_latency got edge %0d want %0d", dc, cap_cyc[i0+4] + 2);
      end
    end
    total++;
    if (lines_written !== 32'd5 || wr_addr !== 64'h1140) begin
      bad++; $display("FAIL basic_final got lw=%0d addr=%h want lw=5 addr=1140", lines_written, wr_addr);
    end
  endtask

  task automatic test_stall();
    bit ok; int dc; int i0; int pushed; logic [63:0] base; logic [63:0] ea;
    sent_q.delete(); i0 = cap_addr.size(); wr_ready = 1'b0;
    base = {32'h0, $urandom_range(0, 1024), 6'h0} & 64'h0000_0000_FFFF_FFC0;
    begin_batch(base, ok);
    pushed = 0;
    for (int g = 0; g < 40 && stall !== 1'b1; g++) begin
      total++;
      if (stall !== (pushed >= DEPTH - 2)) begin
        bad++; $display("FAIL stall_level got %b want %b at count %0d", stall, pushed >= DEPTH - 2, pushed);
      end
      output_valid = 1'b1; output_data = rnd_line();
      sent_q.push_back(output_data); pushed++;
      tick();
    end
    output_valid = 1'b0;
    total++;
    if (pushed !== DEPTH - 2 || stall !== 1'b1) begin
      bad++; $display("FAIL stall_rise got count=%0d stall=%b want count=%0d stall=1", pushed, stall, DEPTH - 2);
    end
    tick();
    wr_ready = 1'b1;
    send_lines(20 - pushed, 1'b1);
    finish_wait(ok, dc);
    total++;
    if (!ok || overflow_err !== 1'b0 || lines_written !== 32'd20) begin
      bad++; $display("FAIL stall_final got done=%b ovf=%b lw=%0d want done=1 ovf=0 lw=20", ok, overflow_err, lines_written);
    end
    for (int k = 0; k < 20; k++) begin
      ea = base + 64'(k) * 64'd64;
      total++;
      if (i0 + k >= cap_addr.size() || cap_addr[i0+k] !== ea || cap_data[i0+k] !== sent_q[k]) begin
        bad++; $display("FAIL stall_line%0d got addr=%h want addr=%h (data order/content)", k,
                        (i0 + k < cap_addr.size()) ? cap_addr[i0+k] : 64'hx, ea);
      end
    end
  endtask

  task automatic test_overflow();
    bit ok; int dc; int i0; logic [63:0] ea;
    sent_q.delete(); i0 = cap_addr.size(); wr_ready = 1'b0;
    begin_batch(64'h8000, ok);
    send_lines(DEPTH + 1, 1'b0);
    total++;
    if (overflow_err !== 1'b1 || stall !== 1'b1) begin
      bad++; $display("FAIL ovf_flag got ovf=%b stall=%b want 1 1", overflow_err, stall);
    end
    wr_ready = 1'b1;
    finish_wait(ok, dc);
    total++;
    if (!ok || cap_addr.size() - i0 !== DEPTH || lines_written !== 32'(DEPTH) || overflow_err !== 1'b1) begin
      bad++; $display("FAIL ovf_final got done=%b writes=%0d lw=%0d ovf=%b want 1 %0d %0d 1",
                      ok, cap_addr.size() - i0, lines_written, overflow_err, DEPTH, DEPTH);
    end
    for (int k = 0; k < DEPTH; k++) begin
      ea = 64'h8000 + 64'(k) * 64'd64;
      total++;
      if (i0 + k >= cap_addr.size() || cap_addr[i0+k] !== ea || cap_data[i0+k] !== sent_q[k]) begin
        bad++; $display("FAIL ovf_line%0d got addr=%h want addr=%h", k,
                        (i0 + k < cap_addr.size()) ? cap_addr[i0+k] : 64'hx, ea);
      end
    end
  endtask

  task automatic test_zero_len();
    bit ok; int dc; int i0;
    i0 = cap_addr.size(); wr_ready = 1'b1;
    begin_batch(64'h2000, ok);
    total++; if (!ok) begin bad++; $display("FAIL zero_permit got 0 want 1"); end
    finish_wait(ok, dc);
    tick();
    total++;
    if (!ok || lines_written !== 32'd0 || output_permit !== 1'b0 || overflow_err !== 1'b0 ||
        cap_addr.size() !== i0 || wr_addr !== 64'h2000) begin
      bad++; $display("FAIL zero_final got done=%b lw=%0d permit=%b ovf=%b writes=%0d addr=%h want 1 0 0 0 0 2000",
                      ok, lines_written, output_permit, overflow_err, cap_addr.size() - i0, wr_addr);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int dc; int i0; logic [63:0] ea;
    sent_q.delete(); wr_ready = 1'b0;
    begin_batch(64'h4000, ok);
    send_lines(3, 1'b1);
    total++;
    if (wr_valid !== 1'b1 || output_permit !== 1'b1) begin
      bad++; $display("FAIL rmid_pre got wr_valid=%b permit=%b want 1 1", wr_valid, output_permit);
    end
    reset = 1'b1;
    tick();
    total++;
    if (output_permit !== 1'b0 || wr_valid !== 1'b0 || stall !== 1'b0 || lines_written !== 32'd0) begin
      bad++; $display("FAIL rmid_after got permit=%b wr_valid=%b stall=%b lw=%0d want 0 0 0 0",
                      output_permit, wr_valid, stall, lines_written);
    end
    reset = 1'b0;
    tick();
    sent_q.delete(); i0 = cap_addr.size(); wr_ready = 1'b1;
    begin_batch(64'h6000, ok);
    send_lines(2, 1'b1);
    finish_wait(ok, dc);
    total++;
    if (!ok || cap_addr.size() - i0 !== 2 || lines_written !== 32'd2) begin
      bad++; $display("FAIL rmid_restart got done=%b writes=%0d lw=%0d want 1 2 2", ok, cap_addr.size() - i0, lines_written);
    end
    for (int k = 0; k < 2; k++) begin
      ea = 64'h6000 + 64'(k) * 64'd64;
      total++;
      if (i0 + k >= cap_addr.size() || cap_addr[i0+k] !== ea || cap_data[i0+k] !== sent_q[k]) begin
        bad++; $display("FAIL rmid_line%0d got addr=%h want addr=%h", k,
                        (i0 + k < cap_addr.size()) ? cap_addr[i0+k] : 64'hx, ea);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok; int dc; int i0; logic [63:0] base; logic [63:0] ea;
    sent_q.delete(); i0 = cap_addr.size(); wr_ready = 1'b1;
    base = 64'hFFFF_FFFF_FFFF_FF80;
    begin_batch(base, ok);
    watch = 1'b1; toggle = 1'b1;
    send_lines(10, 1'b1);
    finish_wait(ok, dc);
    toggle = 1'b0; watch = 1'b0;
    total++;
    if (!ok || unstable !== 0 || lines_written !== 32'd10) begin
      bad++; $display("FAIL b2b_final got done=%b unstable=%0d lw=%0d want 1 0 10", ok, unstable, lines_written);
    end
    for (int k = 0; k < 10; k++) begin
      ea = base + 64'(k) * 64'd64;
      total++;
      if (i0 + k >= cap_addr.size() || cap_addr[i0+k] !== ea || cap_data[i0+k] !== sent_q[k]) begin
        bad++; $display("FAIL b2b_line%0d got addr=%h want addr=%h", k,
                        (i0 + k < cap_addr.size()) ? cap_addr[i0+k] : 64'hx, ea);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_zero_len();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
